// File: rtl/proc_pkg.sv
// Shared types for the self-sequencing datapath control unit.
package proc_pkg;

    typedef enum logic [1:0] {
        OP_LDMV = 2'b00,
        OP_IMOV = 2'b01,
        OP_ADDI = 2'b10,
        OP_SUBI = 2'b11
    } op_e;

    // Function codes double as ALU operation encodings.
    typedef enum logic [3:0] {
        F_LOAD  = 4'h0,
        F_COPY  = 4'h1,
        F_ADD   = 4'h2,
        F_SUB   = 4'h3,
        F_NEG   = 4'h4,
        F_NOT   = 4'h5,
        F_AND   = 4'h6,
        F_OR    = 4'h7,
        F_XOR   = 4'h8,
        F_LSL   = 4'h9,
        F_LSR   = 4'hA,
        F_ASR   = 4'hB,
        F_RSV_C = 4'hC,
        F_RSV_D = 4'hD,
        F_RSV_E = 4'hE,
        F_RSV_F = 4'hF
    } func_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    typedef enum logic [2:0] {
        CLS_LOAD    = 3'd0,
        CLS_COPY    = 3'd1,
        CLS_BINARY  = 3'd2,
        CLS_UNARY   = 3'd3,
        CLS_IMM_MOV = 3'd4,
        CLS_IMM_ALU = 3'd5,
        CLS_ILLEGAL = 3'd6
    } cls_e;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;

endpackage

// File: rtl/proc_instr_decode.sv
// Combinational field extraction and instruction classification of the IR.
module proc_instr_decode
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned NREG       = 4,
    parameter bit          IMM_SIGNED = 1'b0
) (
    input  logic [DATA_W-1:0]        ir_i,
    output op_e                      op_o,
    output logic [$clog2(NREG)-1:0]  rx_o,
    output logic [$clog2(NREG)-1:0]  ry_o,
    output func_e                    func_o,
    output logic [DATA_W-1:0]        imm_o,
    output cls_e                     cls_o
);
    localparam int unsigned REG_AW = $clog2(NREG);
    localparam int unsigned IMM_W  = DATA_W - 2 - REG_AW;

    logic sign_bit;

    assign op_o     = op_e'(ir_i[DATA_W-1 -: 2]);
    assign rx_o     = ir_i[DATA_W-3 -: REG_AW];
    assign ry_o     = ir_i[DATA_W-3-REG_AW -: REG_AW];
    assign func_o   = func_e'(ir_i[3:0]);
    assign sign_bit = IMM_SIGNED ? ir_i[IMM_W-1] : 1'b0;
    assign imm_o    = {{(DATA_W-IMM_W){sign_bit}}, ir_i[IMM_W-1:0]};

    always_comb begin
        cls_o = CLS_ILLEGAL;
        unique case (op_o)
            OP_IMOV:          cls_o = CLS_IMM_MOV;
            OP_ADDI, OP_SUBI: cls_o = CLS_IMM_ALU;
            default: begin
                case (func_o)
                    F_LOAD:                   cls_o = CLS_LOAD;
                    F_COPY:                   cls_o = CLS_COPY;
                    F_NEG, F_NOT:             cls_o = CLS_UNARY;
                    F_ADD, F_SUB, F_AND, F_OR,
                    F_XOR, F_LSL, F_LSR, F_ASR: cls_o = CLS_BINARY;
                    default:                  cls_o = CLS_ILLEGAL;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/proc_sequencer.sv
// Self-sequencing control unit: latches instructions and walks T0-T3 driving datapath strobes.
module proc_sequencer
    import proc_pkg::*;
#(
    parameter int unsigned DATA_W     = 10,
    parameter int unsigned NREG       = 4,
    parameter bit          IMM_SIGNED = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_W-1:0]        instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic                     ext,
    output logic                     ir_in,
    output logic [$clog2(NREG)-1:0]  rin,
    output logic [$clog2(NREG)-1:0]  rout,
    output logic                     enw,
    output logic                     enr,
    output logic                     ain,
    output logic                     gin,
    output logic                     gout,
    output logic [3:0]               alu_op,
    output logic [DATA_W-1:0]        imm,
    output logic                     imm_en,
    output logic                     busy,
    output logic                     done,
    output logic                     illegal
);
    localparam int unsigned REG_AW = $clog2(NREG);

    step_e               step_q, step_d;
    logic [DATA_W-1:0]   ir_q, ir_d;

    op_e                 op;
    logic [REG_AW-1:0]   rx, ry;
    func_e               func;
    logic [DATA_W-1:0]   imm_x;
    cls_e                cls;

    proc_instr_decode #(
        .DATA_W     (DATA_W),
        .NREG       (NREG),
        .IMM_SIGNED (IMM_SIGNED)
    ) u_decode (
        .ir_i   (ir_q),
        .op_o   (op),
        .rx_o   (rx),
        .ry_o   (ry),
        .func_o (func),
        .imm_o  (imm_x),
        .cls_o  (cls)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            step_q <= T0;
            ir_q   <= '0;
        end else begin
            step_q <= step_d;
            ir_q   <= ir_d;
        end
    end

    // Next step and strobes; reset forces every output low regardless of step.
    always_comb begin
        step_d      = step_q;
        ir_d        = ir_q;
        instr_ready = 1'b0;
        ext         = 1'b0;
        ir_in       = 1'b0;
        rin         = '0;
        rout        = '0;
        enw         = 1'b0;
        enr         = 1'b0;
        ain         = 1'b0;
        gin         = 1'b0;
        gout        = 1'b0;
        alu_op      = 4'b0000;
        imm         = '0;
        imm_en      = 1'b0;
        done        = 1'b0;
        illegal     = 1'b0;
        busy        = (step_q != T0);

        unique case (step_q)
            T0: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ext    = 1'b1;
                    ir_in  = 1'b1;
                    ir_d   = instr;
                    step_d = T1;
                end
            end
            T1: begin
                step_d = T0;
                case (cls)
                    CLS_LOAD: begin
                        instr_ready = 1'b1;
                        if (instr_valid) begin
                            ext  = 1'b1;
                            rin  = rx;
                            enw  = 1'b1;
                            done = 1'b1;
                        end else begin
                            step_d = T1;
                        end
                    end
                    CLS_COPY: begin
                        rout = ry;
                        enr  = 1'b1;
                        rin  = rx;
                        enw  = 1'b1;
                        done = 1'b1;
                    end
                    CLS_BINARY, CLS_IMM_ALU: begin
                        rout   = rx;
                        enr    = 1'b1;
                        ain    = 1'b1;
                        step_d = T2;
                    end
                    CLS_UNARY: begin
                        rout   = ry;
                        enr    = 1'b1;
                        gin    = 1'b1;
                        alu_op = func;
                        step_d = T2;
                    end
                    CLS_IMM_MOV: begin
                        imm_en = 1'b1;
                        imm    = imm_x;
                        rin    = rx;
                        enw    = 1'b1;
                        done   = 1'b1;
                    end
                    default: begin
                        illegal = 1'b1;
                        done    = 1'b1;
                    end
                endcase
            end
            T2: begin
                step_d = T0;
                case (cls)
                    CLS_BINARY: begin
                        rout   = ry;
                        enr    = 1'b1;
                        gin    = 1'b1;
                        alu_op = func;
                        step_d = T3;
                    end
                    CLS_IMM_ALU: begin
                        imm_en = 1'b1;
                        imm    = imm_x;
                        gin    = 1'b1;
                        alu_op = (op == OP_ADDI) ? ALU_ADD : ALU_SUB;
                        step_d = T3;
                    end
                    CLS_UNARY: begin
                        rin  = rx;
                        enw  = 1'b1;
                        gout = 1'b1;
                        done = 1'b1;
                    end
                    default: ;
                endcase
            end
            T3: begin
                step_d = T0;
                if (cls == CLS_BINARY || cls == CLS_IMM_ALU) begin
                    rin  = rx;
                    enw  = 1'b1;
                    gout = 1'b1;
                    done = 1'b1;
                end
            end
            default: step_d = T0;
        endcase

        if (reset) begin
            instr_ready = 1'b0;
            ext         = 1'b0;
            ir_in       = 1'b0;
            rin         = '0;
            rout        = '0;
            enw         = 1'b0;
            enr         = 1'b0;
            ain         = 1'b0;
            gin         = 1'b0;
            gout        = 1'b0;
            alu_op      = 4'b0000;
            imm         = '0;
            imm_en      = 1'b0;
            busy        = 1'b0;
            done        = 1'b0;
            illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_proc_sequencer.sv
// Scoreboard bench for proc_sequencer: default, sign-extending and 12-bit/8-register instances.
module tb_proc_sequencer;

    typedef struct packed {
        logic       instr_ready;
        logic       ext;
        logic       ir_in;
        logic [1:0] rin;
        logic [1:0] rout;
        logic       enw;
        logic       enr;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alu_op;
        logic [9:0] imm;
        logic       imm_en;
        logic       busy;
        logic       done;
        logic       illegal;
    } rec_t;

    typedef struct packed {
        logic        instr_ready;
        logic        ext;
        logic        ir_in;
        logic [2:0]  rin;
        logic [2:0]  rout;
        logic        enw;
        logic        enr;
        logic        ain;
        logic        gin;
        logic        gout;
        logic [3:0]  alu_op;
        logic [11:0] imm;
        logic        imm_en;
        logic        busy;
        logic        done;
        logic        illegal;
    } wrec_t;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [9:0] instr;
    } stim_t;

    typedef struct packed {
        logic        valid;
        logic [11:0] instr;
    } wstim_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, instr_valid, w_valid;
    logic [9:0]  instr;
    logic [11:0] w_instr;

    logic        d_ready, d_ext, d_irin, d_enw, d_enr, d_ain, d_gin, d_gout, d_immen, d_busy, d_done, d_ill;
    logic [1:0]  d_rin, d_rout;
    logic [3:0]  d_alu;
    logic [9:0]  d_imm;
    logic        s_ready, s_ext, s_irin, s_enw, s_enr, s_ain, s_gin, s_gout, s_immen, s_busy, s_done, s_ill;
    logic [1:0]  s_rin, s_rout;
    logic [3:0]  s_alu;
    logic [9:0]  s_imm;
    logic        w_ready, w_ext, w_irin, w_enw, w_enr, w_ain, w_gin, w_gout, w_immen, w_busy, w_done, w_ill;
    logic [2:0]  w_rin, w_rout;
    logic [3:0]  w_alu;
    logic [11:0] w_imm;

    proc_sequencer dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(d_ready), .ext(d_ext), .ir_in(d_irin), .rin(d_rin), .rout(d_rout),
        .enw(d_enw), .enr(d_enr), .ain(d_ain), .gin(d_gin), .gout(d_gout), .alu_op(d_alu),
        .imm(d_imm), .imm_en(d_immen), .busy(d_busy), .done(d_done), .illegal(d_ill)
    );

    proc_sequencer #(.DATA_W(10), .NREG(4), .IMM_SIGNED(1'b1)) dut_s (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(s_ready), .ext(s_ext), .ir_in(s_irin), .rin(s_rin), .rout(s_rout),
        .enw(s_enw), .enr(s_enr), .ain(s_ain), .gin(s_gin), .gout(s_gout), .alu_op(s_alu),
        .imm(s_imm), .imm_en(s_immen), .busy(s_busy), .done(s_done), .illegal(s_ill)
    );

    proc_sequencer #(.DATA_W(12), .NREG(8), .IMM_SIGNED(1'b0)) dut_w (
        .clk(clk), .reset(reset), .instr(w_instr), .instr_valid(w_valid),
        .instr_ready(w_ready), .ext(w_ext), .ir_in(w_irin), .rin(w_rin), .rout(w_rout),
        .enw(w_enw), .enr(w_enr), .ain(w_ain), .gin(w_gin), .gout(w_gout), .alu_op(w_alu),
        .imm(w_imm), .imm_en(w_immen), .busy(w_busy), .done(w_done), .illegal(w_ill)
    );

    rec_t  obs_d, obs_s;
    wrec_t obs_w;
    assign obs_d = {d_ready, d_ext, d_irin, d_rin, d_rout, d_enw, d_enr, d_ain, d_gin, d_gout,
                    d_alu, d_imm, d_immen, d_busy, d_done, d_ill};
    assign obs_s = {s_ready, s_ext, s_irin, s_rin, s_rout, s_enw, s_enr, s_ain, s_gin, s_gout,
                    s_alu, s_imm, s_immen, s_busy, s_done, s_ill};
    assign obs_w = {w_ready, w_ext, w_irin, w_rin, w_rout, w_enw, w_enr, w_ain, w_gin, w_gout,
                    w_alu, w_imm, w_immen, w_busy, w_done, w_ill};

    stim_t      stim_q[$];
    rec_t       exp_q[$];
    logic [9:0] imms_q[$];
    wstim_t     wstim_q[$];
    wrec_t      wexp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic rec_t idle_r();
        rec_t r = '0;
        r.instr_ready = 1'b1;
        return r;
    endfunction

    function automatic rec_t acc_r();
        rec_t r = '0;
        r.instr_ready = 1'b1;
        r.ext         = 1'b1;
        r.ir_in       = 1'b1;
        return r;
    endfunction

    function automatic rec_t busy_r();
        rec_t r = '0;
        r.busy = 1'b1;
        return r;
    endfunction

    task automatic push(input logic rst, input logic valid, input logic [9:0] ins,
                        input rec_t e, input logic [9:0] imm_s);
        stim_t s;
        s.rst = rst; s.valid = valid; s.instr = ins;
        stim_q.push_back(s);
        exp_q.push_back(e);
        imms_q.push_back(imm_s);
    endtask

    task automatic test_reset();
        int cyc = 0;
        push(1'b1, 1'b1, 10'h062, '0, 10'h000);
        push(1'b1, 1'b1, 10'h062, '0, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        while (stim_q.size() > 0) begin
            stim_t s; rec_t e; logic [9:0] es;
            s = stim_q.pop_front();
            reset = s.rst; instr_valid = s.valid; instr = s.instr;
            @(negedge clk);
            e = exp_q.pop_front(); es = imms_q.pop_front();
            n_checks++;
            if (obs_d !== e) begin
                n_fail++;
                $display("FAIL reset cyc%0d: dut %h expected %h", cyc, obs_d, e);
            end
            e.imm = es;
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL reset_signed cyc%0d: dut %h expected %h", cyc, obs_s, e);
            end
            n_checks++;
            if (s.rst && obs_w !== '0) begin
                n_fail++;
                $display("FAIL reset_wide cyc%0d: dut %h expected 0", cyc, obs_w);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_add();
        int cyc = 0;
        rec_t r;
        push(1'b0, 1'b1, 10'h062, acc_r(), 10'h000);
        r = busy_r(); r.rout = 2'd1; r.enr = 1'b1; r.ain = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        r = busy_r(); r.rout = 2'd2; r.enr = 1'b1; r.gin = 1'b1; r.alu_op = 4'b0010;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        r = busy_r(); r.rin = 2'd1; r.enw = 1'b1; r.gout = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        while (stim_q.size() > 0) begin
            stim_t s; rec_t e; logic [9:0] es;
            s = stim_q.pop_front();
            reset = s.rst; instr_valid = s.valid; instr = s.instr;
            @(negedge clk);
            e = exp_q.pop_front(); es = imms_q.pop_front();
            n_checks++;
            if (obs_d !== e) begin
                n_fail++;
                $display("FAIL add cyc%0d: dut %h expected %h", cyc, obs_d, e);
            end
            e.imm = es;
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL add_signed cyc%0d: dut %h expected %h", cyc, obs_s, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_imm_alu();
        int cyc = 0;
        rec_t r;
        push(1'b0, 1'b1, 10'h2ED, acc_r(), 10'h000);
        r = busy_r(); r.rout = 2'd3; r.enr = 1'b1; r.ain = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        r = busy_r(); r.imm_en = 1'b1; r.imm = 10'h02D; r.gin = 1'b1; r.alu_op = 4'b0010;
        push(1'b0, 1'b0, 10'h000, r, 10'h3ED);
        r = busy_r(); r.rin = 2'd3; r.enw = 1'b1; r.gout = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        while (stim_q.size() > 0) begin
            stim_t s; rec_t e; logic [9:0] es;
            s = stim_q.pop_front();
            reset = s.rst; instr_valid = s.valid; instr = s.instr;
            @(negedge clk);
            e = exp_q.pop_front(); es = imms_q.pop_front();
            n_checks++;
            if (obs_d !== e) begin
                n_fail++;
                $display("FAIL addi cyc%0d: dut %h expected %h", cyc, obs_d, e);
            end
            e.imm = es;
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL addi_signed cyc%0d: dut %h expected %h", cyc, obs_s, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_stall();
        int cyc = 0;
        rec_t r;
        push(1'b0, 1'b1, 10'h0C0, acc_r(), 10'h000);
        r = busy_r(); r.instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 10'h155, r, 10'h000);
        r = busy_r(); r.instr_ready = 1'b1; r.ext = 1'b1; r.rin = 2'd3; r.enw = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b1, 10'h155, r, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        while (stim_q.size() > 0) begin
            stim_t s; rec_t e; logic [9:0] es;
            s = stim_q.pop_front();
            reset = s.rst; instr_valid = s.valid; instr = s.instr;
            @(negedge clk);
            e = exp_q.pop_front(); es = imms_q.pop_front();
            n_checks++;
            if (obs_d !== e) begin
                n_fail++;
                $display("FAIL load cyc%0d: dut %h expected %h", cyc, obs_d, e);
            end
            e.imm = es;
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL load_signed cyc%0d: dut %h expected %h", cyc, obs_s, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal_and_abort();
        int cyc = 0;
        rec_t r;
        push(1'b0, 1'b1, 10'h00E, acc_r(), 10'h000);
        r = busy_r(); r.illegal = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        // sub R2,R1 aborted by reset in its T2
        push(1'b0, 1'b1, 10'h093, acc_r(), 10'h000);
        r = busy_r(); r.rout = 2'd2; r.enr = 1'b1; r.ain = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        push(1'b1, 1'b0, 10'h000, '0, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        while (stim_q.size() > 0) begin
            stim_t s; rec_t e; logic [9:0] es;
            s = stim_q.pop_front();
            reset = s.rst; instr_valid = s.valid; instr = s.instr;
            @(negedge clk);
            e = exp_q.pop_front(); es = imms_q.pop_front();
            n_checks++;
            if (obs_d !== e) begin
                n_fail++;
                $display("FAIL illegal_abort cyc%0d: dut %h expected %h", cyc, obs_d, e);
            end
            e.imm = es;
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL illegal_abort_signed cyc%0d: dut %h expected %h", cyc, obs_s, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        int cyc = 0;
        rec_t r;
        push(1'b0, 1'b1, 10'h031, acc_r(), 10'h000);
        // movi offered while copy finishes must be ignored
        r = busy_r(); r.rout = 2'd3; r.enr = 1'b1; r.rin = 2'd0; r.enw = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b1, 10'h185, r, 10'h000);
        push(1'b0, 1'b1, 10'h185, acc_r(), 10'h000);
        r = busy_r(); r.imm_en = 1'b1; r.imm = 10'h005; r.rin = 2'd2; r.enw = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b1, 10'h065, r, 10'h005);
        push(1'b0, 1'b1, 10'h065, acc_r(), 10'h000);
        r = busy_r(); r.rout = 2'd2; r.enr = 1'b1; r.gin = 1'b1; r.alu_op = 4'b0101;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        r = busy_r(); r.rin = 2'd1; r.enw = 1'b1; r.gout = 1'b1; r.done = 1'b1;
        push(1'b0, 1'b0, 10'h000, r, 10'h000);
        push(1'b0, 1'b0, 10'h000, idle_r(), 10'h000);
        while (stim_q.size() > 0) begin
            stim_t s; rec_t e; logic [9:0] es;
            s = stim_q.pop_front();
            reset = s.rst; instr_valid = s.valid; instr = s.instr;
            @(negedge clk);
            e = exp_q.pop_front(); es = imms_q.pop_front();
            n_checks++;
            if (obs_d !== e) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: dut %h expected %h", cyc, obs_d, e);
            end
            e.imm = es;
            n_checks++;
            if (obs_s !== e) begin
                n_fail++;
                $display("FAIL back_to_back_signed cyc%0d: dut %h expected %h", cyc, obs_s, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wide_neg();
        int cyc = 0;
        wstim_t ws;
        wrec_t  r;
        ws.valid = 1'b1; ws.instr = 12'h2E4;
        wstim_q.push_back(ws);
        r = '0; r.instr_ready = 1'b1; r.ext = 1'b1; r.ir_in = 1'b1;
        wexp_q.push_back(r);
        ws.valid = 1'b0; ws.instr = 12'h000;
        wstim_q.push_back(ws);
        r = '0; r.busy = 1'b1; r.rout = 3'd6; r.enr = 1'b1; r.gin = 1'b1; r.alu_op = 4'b0100;
        wexp_q.push_back(r);
        wstim_q.push_back(ws);
        r = '0; r.busy = 1'b1; r.rin = 3'd5; r.enw = 1'b1; r.gout = 1'b1; r.done = 1'b1;
        wexp_q.push_back(r);
        wstim_q.push_back(ws);
        r = '0; r.instr_ready = 1'b1;
        wexp_q.push_back(r);
        while (wstim_q.size() > 0) begin
            wrec_t e;
            ws = wstim_q.pop_front();
            w_valid = ws.valid; w_instr = ws.instr;
            @(negedge clk);
            e = wexp_q.pop_front();
            n_checks++;
            if (obs_w !== e) begin
                n_fail++;
                $display("FAIL wide_neg cyc%0d: dut %h expected %h", cyc, obs_w, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = '0;
        w_valid = 1'b0; w_instr = '0;
        test_reset();
        test_add();
        test_imm_alu();
        test_load_stall();
        test_illegal_and_abort();
        test_back_to_back();
        test_wide_neg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
